// File: rtl/k2_sequencer.sv
// K2 fetch/execute sequencer: fetches over a req/valid port, drives the ALU block,
// writes results back and snapshots the ALU's registered C/Z for conditional jumps.
module k2_sequencer #(
  parameter int bits = 8,
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            instr_req,
  output logic [PC_W-1:0] instr_addr,
  input  logic            instr_valid,
  input  logic [7:0]      instr_data,
  output logic [bits-1:0] alu_a,
  output logic [bits-1:0] alu_b,
  output logic            alu_s,
  input  logic [bits-1:0] alu_out,
  input  logic            alu_c,
  input  logic            alu_z,
  output logic [bits-1:0] ro,
  output logic            halted
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    FLAGS = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [7:0]      ir;
  logic [bits-1:0] ra;
  logic [bits-1:0] rb;
  logic [bits-1:0] ro_reg;
  logic            cf;
  logic            zf;
  logic            req_reg;
  logic            halted_reg;

  logic            take;
  logic [bits-1:0] ldi_val;
  logic [PC_W-1:0] jmp_target;
  logic [PC_W-1:0] pc_inc;

  always_comb begin
    take = 1'b0;
    case (ir[5:4])
      2'b00:   take = 1'b1;
      2'b01:   take = cf;
      2'b10:   take = zf;
      default: take = ~zf;
    endcase
  end

  assign ldi_val    = bits'(ir[3:0]);
  assign jmp_target = PC_W'(ir[3:0]);
  assign pc_inc     = pc + 1'b1;

  // Operands and add/sub come straight from registers so they hold steady into FLAGS,
  // letting the ALU's registered flags reflect the EXEC operation.
  assign alu_a      = ra;
  assign alu_b      = rb;
  assign alu_s      = ir[3];
  assign instr_req  = req_reg;
  assign instr_addr = pc;
  assign ro         = ro_reg;
  assign halted     = halted_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= '0;
      ir         <= '0;
      ra         <= '0;
      rb         <= '0;
      ro_reg     <= '0;
      cf         <= 1'b0;
      zf         <= 1'b0;
      req_reg    <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state   <= FETCH;
          req_reg <= 1'b1;
        end
        FETCH: begin
          if (instr_valid) begin
            ir      <= instr_data;
            state   <= EXEC;
            req_reg <= 1'b0;
          end
        end
        EXEC: begin
          case (ir[7:6])
            2'b00: begin
              case (ir[5:4])
                2'b00:   ra     <= alu_out;
                2'b01:   rb     <= alu_out;
                2'b10:   ro_reg <= alu_out;
                default: ;
              endcase
              pc    <= pc_inc;
              state <= FLAGS;
            end
            2'b01: begin
              case (ir[5:4])
                2'b00:   ra     <= ldi_val;
                2'b01:   rb     <= ldi_val;
                2'b10:   ro_reg <= ldi_val;
                default: ;
              endcase
              pc      <= pc_inc;
              state   <= FETCH;
              req_reg <= 1'b1;
            end
            2'b10: begin
              pc      <= take ? jmp_target : pc_inc;
              state   <= FETCH;
              req_reg <= 1'b1;
            end
            default: begin
              state      <= HALT;
              halted_reg <= 1'b1;
            end
          endcase
        end
        FLAGS: begin
          cf      <= alu_c;
          zf      <= alu_z;
          state   <= FETCH;
          req_reg <= 1'b1;
        end
        HALT: begin
          halted_reg <= 1'b1;
          req_reg    <= 1'b0;
        end
        default: begin
          state   <= BOOT;
          req_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_k2_sequencer.sv
// Bench for k2_sequencer: plays the instruction memory and a flag-registering ALU,
// runs a directed program table, reset corner cases and random programs vs an ISA model.
module tb_k2_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_req;
  logic [3:0] instr_addr;
  logic       instr_valid;
  logic [7:0] instr_data;
  logic [7:0] alu_a, alu_b, alu_out, ro;
  logic       alu_s, alu_c, alu_z, halted;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Simple ALU block: combinational result, flags registered every clock.
  logic [8:0] alu_wide;
  always_comb alu_wide = alu_s ? ({1'b0, alu_a} - {1'b0, alu_b}) : ({1'b0, alu_a} + {1'b0, alu_b});
  assign alu_out = alu_wide[7:0];
  always @(posedge clk) begin
    alu_c <= alu_wide[8];
    alu_z <= (alu_wide[7:0] == 8'h00);
  end

  k2_sequencer #(.bits(8), .PC_W(4)) dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr_data(instr_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z),
    .ro(ro), .halted(halted)
  );

  typedef struct {
    logic [7:0] instr;
    logic [3:0] addr;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] ro;
    int         cyc;
  } vec_t;

  vec_t vec[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (instr_req === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL req_timeout actual=instr_req stuck low required=instr_req high");
  endtask

  // Called at a negedge with instr_req high; stalls, then hands over one word.
  task automatic serve(input logic [7:0] data, input int stalls);
    logic [3:0] a0;
    logic [7:0] ra0, rb0, ro0;
    a0 = instr_addr; ra0 = alu_a; rb0 = alu_b; ro0 = ro;
    for (int s = 0; s < stalls; s++) begin
      instr_valid = 1'b0;
      instr_data  = 8'($urandom);
      @(negedge clk);
      check("stall_req", instr_req, 1);
      check("stall_addr", instr_addr, a0);
      check("stall_regs", {ra0, rb0, ro0}, {alu_a, alu_b, ro});
    end
    instr_valid = 1'b1;
    instr_data  = data;
    @(negedge clk);
    instr_valid = 1'b0;
    instr_data  = 8'($urandom);
  endtask

  logic [7:0] mem[16];
  logic [3:0] m_pc;
  logic [7:0] m_ra, m_rb, m_ro;
  logic       m_cf, m_zf;

  task automatic model_write(input logic [1:0] dest, input logic [7:0] val);
    case (dest)
      2'd0: m_ra = val;
      2'd1: m_rb = val;
      2'd2: m_ro = val;
      default: ;
    endcase
  endtask

  // Executes one instruction at ISA level; returns its cycle cost.
  task automatic model_step(output int cyc);
    logic [7:0] ins, res;
    logic       take;
    ins = mem[m_pc];
    cyc = 2;
    case (ins[7:6])
      2'b00: begin
        if (ins[3]) begin
          res  = m_ra - m_rb;
          m_cf = (m_ra < m_rb);
        end else begin
          res  = m_ra + m_rb;
          m_cf = (int'(m_ra) + int'(m_rb) > 255);
        end
        m_zf = (res == 8'd0);
        model_write(ins[5:4], res);
        m_pc = m_pc + 4'd1;
        cyc  = 3;
      end
      2'b01: begin
        model_write(ins[5:4], {4'd0, ins[3:0]});
        m_pc = m_pc + 4'd1;
      end
      2'b10: begin
        case (ins[5:4])
          2'd0: take = 1'b1;
          2'd1: take = m_cf;
          2'd2: take = m_zf;
          default: take = !m_zf;
        endcase
        m_pc = take ? ins[3:0] : m_pc + 4'd1;
      end
      default: ;
    endcase
  endtask

  initial begin
    bit ok;
    int start, prev_stalls, st, cyc_exp;

    // LDI=0x4X/5X/6X, ALU=0x00|dest<<4|s<<3, JMP=0x8X..0xBX, HALT=0xC0
    vec[0]  = '{8'h45, 4'h0, 8'h05, 8'h00, 8'h00, 2};
    vec[1]  = '{8'h53, 4'h1, 8'h05, 8'h03, 8'h00, 2};
    vec[2]  = '{8'h20, 4'h2, 8'h05, 8'h03, 8'h08, 3};
    vec[3]  = '{8'hAA, 4'h3, 8'h05, 8'h03, 8'h08, 2};
    vec[4]  = '{8'h40, 4'h4, 8'h00, 8'h03, 8'h08, 2};
    vec[5]  = '{8'h51, 4'h5, 8'h00, 8'h01, 8'h08, 2};
    vec[6]  = '{8'h08, 4'h6, 8'hFF, 8'h01, 8'h08, 3};
    vec[7]  = '{8'h00, 4'h7, 8'h00, 8'h01, 8'h08, 3};
    vec[8]  = '{8'h9A, 4'h8, 8'h00, 8'h01, 8'h08, 2};
    vec[9]  = '{8'hB3, 4'hA, 8'h00, 8'h01, 8'h08, 2};
    vec[10] = '{8'h41, 4'hB, 8'h01, 8'h01, 8'h08, 2};
    vec[11] = '{8'h00, 4'hC, 8'h02, 8'h01, 8'h08, 3};
    vec[12] = '{8'hA5, 4'hD, 8'h02, 8'h01, 8'h08, 2};
    vec[13] = '{8'h8F, 4'hE, 8'h02, 8'h01, 8'h08, 2};
    vec[14] = '{8'h70, 4'hF, 8'h02, 8'h01, 8'h08, 2};
    vec[15] = '{8'hB2, 4'h0, 8'h02, 8'h01, 8'h08, 2};
    vec[16] = '{8'h18, 4'h2, 8'h02, 8'h01, 8'h08, 3};
    vec[17] = '{8'hC0, 4'h3, 8'h02, 8'h01, 8'h08, 2};

    rst = 1'b1;
    instr_valid = 1'b0;
    instr_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_outputs", {instr_req, instr_addr, alu_a, alu_b, alu_s, ro, halted}, 0);
    rst = 1'b0;
    #1 check("boot_req", instr_req, 0);
    @(negedge clk);

    prev_stalls = 0;
    start = 0;
    for (int i = 0; i < 18; i++) begin
      wait_req(ok);
      if (!ok) break;
      if (i > 0) begin
        check($sformatf("cyc_row%0d", i - 1), cyc_cnt - start - prev_stalls, vec[i-1].cyc);
        check($sformatf("regs_row%0d", i - 1), {alu_a, alu_b, ro}, {vec[i-1].ra, vec[i-1].rb, vec[i-1].ro});
      end
      check($sformatf("addr_row%0d", i), instr_addr, vec[i].addr);
      start = cyc_cnt;
      st = (i == 4) ? 3 : $urandom_range(0, 2);
      serve(vec[i].instr, st);
      prev_stalls = st;
    end
    check("halt_exec", halted, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("halt_state", {halted, instr_req}, 2'b10);
    end

    // Reset out of HALT, then reset in the middle of an ADD->RO EXEC.
    rst = 1'b1;
    #1 check("halt_rst", {halted, instr_req}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wait_req(ok);
    serve(8'h47, 0);
    wait_req(ok);
    serve(8'h51, 0);
    wait_req(ok);
    serve(8'h20, 0);
    check("exec_operands", {alu_a, alu_b}, {8'h07, 8'h01});
    #2 rst = 1'b1;
    #1 check("midrst_out", {instr_req, instr_addr, alu_a, alu_b, alu_s, ro, halted}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_boot", instr_req, 0);
    @(negedge clk);
    check("midrst_fetch", {instr_req, instr_addr, ro}, {1'b1, 4'h0, 8'h00});

    for (int p = 0; p < 2; p++) begin
      if (p > 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
      end
      for (int a = 0; a < 16; a++) begin
        mem[a] = 8'($urandom);
        if (mem[a][7:6] == 2'b11) mem[a][7:6] = 2'b00;
      end
      m_pc = 0; m_ra = 0; m_rb = 0; m_ro = 0; m_cf = 0; m_zf = 0;
      cyc_exp = 0;
      prev_stalls = 0;
      for (int n = 0; n < 150; n++) begin
        wait_req(ok);
        if (!ok) break;
        if (n > 0) check("rnd_cyc", cyc_cnt - start - prev_stalls, cyc_exp);
        check("rnd_addr", instr_addr, m_pc);
        check("rnd_regs", {alu_a, alu_b, ro}, {m_ra, m_rb, m_ro});
        start = cyc_cnt;
        st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        serve(mem[m_pc], st);
        prev_stalls = st;
        model_step(cyc_exp);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
